watch_edit_ctrl: RTL and testbench

WATCH_EDIT_CTRL -- requirements
Module: watch_edit_ctrl

---
 rtl/watch_edit_ctrl_if.sv | 25 ++
 rtl/watch_edit_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_watch_edit_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/watch_edit_ctrl_if.sv
// Button/tick inputs and edit-command outputs of the watch edit controller.
interface watch_edit_ctrl_if;
    logic       tick_100hz;
    logic       btn_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       edit_mode;
    logic [1:0] cursor;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       reset_pulse;
    logic       blink;

    modport master (
        output tick_100hz, btn_mode, btn_left, btn_right, btn_up, btn_down,
        input  edit_mode, cursor, inc_pulse, dec_pulse, reset_pulse, blink
    );

    modport slave (
        input  tick_100hz, btn_mode, btn_left, btn_right, btn_up, btn_down,
        output edit_mode, cursor, inc_pulse, dec_pulse, reset_pulse, blink
    );
endinterface

// File: rtl/watch_edit_ctrl.sv
// Watch edit controller: button edges move the cursor and issue inc/dec/reset strobes, with blink and edit timeout.
// Held up/down auto-repeat (HOLD state) is compiled in only when WATCH_AUTOREPEAT_EN is defined.
module watch_edit_ctrl #(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter int EDIT_TIMEOUT = 1000,
    parameter int BLINK_HALF   = 25
) (
    input  logic             clk,
    input  logic             reset,
    watch_edit_ctrl_if.slave bus
);

    localparam int TO_W = $clog2(EDIT_TIMEOUT + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(EDIT_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF);
    localparam logic [BL_W-1:0] BL_ONE = BL_W'(1);

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || EDIT_TIMEOUT < 1 || BLINK_HALF < 1) begin : g_param_check
        $error("watch_edit_ctrl: timing parameters must all be at least 1");
    end

`ifdef WATCH_AUTOREPEAT_EN
    localparam int RP_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_TOP + 1);
    localparam logic [RP_W-1:0] RP_MAX   = RP_W'(RP_TOP);
    localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);
    localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1
`ifdef WATCH_AUTOREPEAT_EN
        , HOLD = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      lvl, prev_q, rise;
    logic            armed_q;
    logic            mode_e, left_e, right_e, up_e, down_e, any_e, combo;
    logic [1:0]      cursor_q, cursor_d;
    logic            inc_q, inc_d, dec_q, dec_d, rstp_q, rstp_d;
    logic [TO_W-1:0] to_q, to_d, to_nxt;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d, bl_nxt;
    logic            blink_q, blink_d;
    logic            enter_edit;
`ifdef WATCH_AUTOREPEAT_EN
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d, rp_nxt, rp_lim;
    logic            rp_run_q, rp_run_d;
    logic            hold_up_q, hold_up_d;
    logic            held;
`endif

    // Edge detection is disarmed for the first clock after reset so held buttons do not fire.
    assign lvl   = {bus.btn_mode, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
    assign rise  = armed_q ? (lvl & ~prev_q) : 5'b00000;
    assign {mode_e, left_e, right_e, up_e, down_e} = rise;
    assign any_e = |rise;
    assign combo = bus.btn_up && bus.btn_down && (up_e || down_e);

    assign to_nxt = (to_q == TO_MAX) ? to_q : to_q + TO_ONE;
    assign bl_nxt = (bl_cnt_q == BL_MAX) ? bl_cnt_q : bl_cnt_q + BL_ONE;

`ifdef WATCH_AUTOREPEAT_EN
    assign rp_nxt = (rp_cnt_q == RP_MAX) ? rp_cnt_q : rp_cnt_q + RP_ONE;
    assign rp_lim = rp_run_q ? RP_RATE : RP_DELAY;
    assign held   = hold_up_q ? bus.btn_up : bus.btn_down;
`endif

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        rstp_d     = 1'b0;
        enter_edit = 1'b0;
        to_d       = any_e ? '0 : to_q;
`ifdef WATCH_AUTOREPEAT_EN
        rp_cnt_d   = rp_cnt_q;
        rp_run_d   = rp_run_q;
        hold_up_d  = hold_up_q;
`endif
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (mode_e) begin
                    state_d    = EDIT;
                    enter_edit = 1'b1;
                end
            end
            EDIT: begin
                if (!any_e && bus.tick_100hz) to_d = to_nxt;
                if (mode_e) begin
                    state_d = IDLE;
                end else if (combo) begin
                    rstp_d = 1'b1;
                end else begin
                    if (right_e && !left_e)      cursor_d = cursor_q + 2'd1;
                    else if (left_e && !right_e) cursor_d = cursor_q - 2'd1;
                    if (up_e) begin
                        inc_d = 1'b1;
`ifdef WATCH_AUTOREPEAT_EN
                        state_d   = HOLD;
                        rp_cnt_d  = '0;
                        rp_run_d  = 1'b0;
                        hold_up_d = 1'b1;
`endif
                    end else if (down_e) begin
                        dec_d = 1'b1;
`ifdef WATCH_AUTOREPEAT_EN
                        state_d   = HOLD;
                        rp_cnt_d  = '0;
                        rp_run_d  = 1'b0;
                        hold_up_d = 1'b0;
`endif
                    end
                    // to_d only reaches the limit when no edge arrived this cycle
                    if (to_d == TO_MAX) state_d = IDLE;
                end
            end
`ifdef WATCH_AUTOREPEAT_EN
            HOLD: begin
                if (mode_e) begin
                    state_d = IDLE;
                end else if (combo) begin
                    rstp_d  = 1'b1;
                    state_d = EDIT;
                end else if (!held) begin
                    state_d = EDIT;
                end else if (bus.tick_100hz) begin
                    if (rp_nxt == rp_lim) begin
                        inc_d    = hold_up_q;
                        dec_d    = !hold_up_q;
                        rp_cnt_d = '0;
                        rp_run_d = 1'b1;
                    end else begin
                        rp_cnt_d = rp_nxt;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) cursor_d = 2'b00;

        // A strobe is never repeated on back-to-back clocks.
        inc_d  = inc_d  && !inc_q;
        dec_d  = dec_d  && !dec_q;
        rstp_d = rstp_d && !rstp_q;
    end

    always_comb begin
        blink_d  = blink_q;
        bl_cnt_d = bl_cnt_q;
        if (state_d == IDLE) begin
            blink_d  = 1'b0;
            bl_cnt_d = '0;
        end else if (enter_edit) begin
            blink_d  = 1'b1;
            bl_cnt_d = '0;
        end else if (bus.tick_100hz) begin
            if (bl_nxt == BL_MAX) begin
                blink_d  = !blink_q;
                bl_cnt_d = '0;
            end else begin
                bl_cnt_d = bl_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            armed_q   <= 1'b0;
            cursor_q  <= 2'b00;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            rstp_q    <= 1'b0;
            to_q      <= '0;
            bl_cnt_q  <= '0;
            blink_q   <= 1'b0;
`ifdef WATCH_AUTOREPEAT_EN
            rp_cnt_q  <= '0;
            rp_run_q  <= 1'b0;
            hold_up_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prev_q    <= lvl;
            armed_q   <= 1'b1;
            cursor_q  <= cursor_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            rstp_q    <= rstp_d;
            to_q      <= to_d;
            bl_cnt_q  <= bl_cnt_d;
            blink_q   <= blink_d;
`ifdef WATCH_AUTOREPEAT_EN
            rp_cnt_q  <= rp_cnt_d;
            rp_run_q  <= rp_run_d;
            hold_up_q <= hold_up_d;
`endif
        end
    end

    assign bus.edit_mode   = (state_q != IDLE);
    assign bus.cursor      = cursor_q;
    assign bus.inc_pulse   = inc_q;
    assign bus.dec_pulse   = dec_q;
    assign bus.reset_pulse = rstp_q;
    assign bus.blink       = blink_q;

endmodule

// File: tb/tb_watch_edit_ctrl.sv
// Directed bench for watch_edit_ctrl: a behavioural model checked every cycle plus literal spot checks.
module tb_watch_edit_ctrl;
    localparam int REPEAT_DELAY = 50;
    localparam int REPEAT_RATE  = 10;
    localparam int EDIT_TIMEOUT = 1000;
    localparam int BLINK_HALF   = 25;

    localparam bit [4:0] B_MODE  = 5'b10000;
    localparam bit [4:0] B_LEFT  = 5'b01000;
    localparam bit [4:0] B_RIGHT = 5'b00100;
    localparam bit [4:0] B_UP    = 5'b00010;
    localparam bit [4:0] B_DOWN  = 5'b00001;

`ifdef WATCH_AUTOREPEAT_EN
    localparam int EXP_UP80   = 5;
    localparam int EXP_DOWN61 = 3;
`else
    localparam int EXP_UP80   = 1;
    localparam int EXP_DOWN61 = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    watch_edit_ctrl_if bus ();

    watch_edit_ctrl #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .EDIT_TIMEOUT (EDIT_TIMEOUT),
        .BLINK_HALF   (BLINK_HALF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int    n_tests  = 0;
    int    n_fail   = 0;
    bit    cmp_en   = 1'b0;
    int    lit_seq  = 0;
    int    lit_done = 0;
    int    lit_act  = 0;
    int    lit_exp  = 0;
    string lit_name = "";
    int    inc_seen = 0;
    int    dec_seen = 0;
    int    rst_seen = 0;

    // Model: state 0 idle, 1 edit, 2 hold; quiet = ticks since last edge, shown = ticks since edit entry.
    int       m_state = 0;
    int       m_cursor = 0;
    int       m_quiet = 0;
    int       m_shown = 0;
    int       m_held_ticks = 0;
    bit       m_held_up = 1'b0;
    bit       m_inc = 1'b0;
    bit       m_dec = 1'b0;
    bit       m_rst = 1'b0;
    bit       m_armed = 1'b0;
    bit [4:0] m_prev = 5'd0;

    always @(posedge clk or posedge reset) begin : model
        bit [4:0] lv;
        bit [4:0] r;
        bit       both;
        bit       entered;
        bit       strobe;
        if (reset) begin
            m_state = 0; m_cursor = 0; m_quiet = 0; m_shown = 0; m_held_ticks = 0;
            m_held_up = 1'b0; m_inc = 1'b0; m_dec = 1'b0; m_rst = 1'b0;
            m_armed = 1'b0; m_prev = 5'd0;
        end else begin
            lv = {bus.btn_mode, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
            r = m_armed ? (lv & ~m_prev) : 5'd0;
            m_prev = lv;
            m_armed = 1'b1;
            m_inc = 1'b0; m_dec = 1'b0; m_rst = 1'b0;
            both = bus.btn_up && bus.btn_down && (r[1] || r[0]);
            entered = 1'b0;
            if (r != 5'd0) m_quiet = 0;
            if (m_state == 0) begin
                if (r[4]) begin
                    m_state = 1; m_cursor = 0; m_quiet = 0; entered = 1'b1;
                end
            end else if (m_state == 1) begin
                if (r == 5'd0 && bus.tick_100hz) m_quiet++;
                if (r[4]) m_state = 0;
                else if (both) m_rst = 1'b1;
                else begin
                    if (r[2] && !r[3]) m_cursor = (m_cursor + 1) % 4;
                    else if (r[3] && !r[2]) m_cursor = (m_cursor + 3) % 4;
                    if (r[1] || r[0]) begin
                        m_inc = r[1];
                        m_dec = !r[1];
`ifdef WATCH_AUTOREPEAT_EN
                        m_state = 2; m_held_up = r[1]; m_held_ticks = 0;
`endif
                    end
                    if (m_quiet >= EDIT_TIMEOUT) m_state = 0;
                end
            end else begin
                if (r[4]) m_state = 0;
                else if (both) begin m_rst = 1'b1; m_state = 1; end
                else if (!(m_held_up ? bus.btn_up : bus.btn_down)) m_state = 1;
                else if (bus.tick_100hz) begin
                    m_held_ticks++;
                    strobe = (m_held_ticks >= REPEAT_DELAY) &&
                             ((m_held_ticks - REPEAT_DELAY) % REPEAT_RATE == 0);
                    m_inc = strobe && m_held_up;
                    m_dec = strobe && !m_held_up;
                end
            end
            if (m_state == 0) m_cursor = 0;
            if (m_state == 0 || entered) m_shown = 0;
            else if (bus.tick_100hz) m_shown++;
        end
    end

    always @(negedge clk) begin : compare
        logic [6:0] act;
        logic [6:0] exp;
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            n_tests++;
            if (lit_act != lit_exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, required %0d (t=%0t)", lit_name, lit_act, lit_exp, $time);
            end
        end
        if (cmp_en) begin
            exp = {m_state != 0, 2'(m_cursor), m_inc, m_dec, m_rst,
                   (m_state != 0) && ((m_shown / BLINK_HALF) % 2 == 0)};
            act = {bus.edit_mode, bus.cursor, bus.inc_pulse, bus.dec_pulse, bus.reset_pulse, bus.blink};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_model {edit,cursor,inc,dec,rst,blink}: got %b, required %b (t=%0t)",
                         act, exp, $time);
            end
        end
        if (bus.inc_pulse === 1'b1)   inc_seen++;
        if (bus.dec_pulse === 1'b1)   dec_seen++;
        if (bus.reset_pulse === 1'b1) rst_seen++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run still active at t=%0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit [4:0] v);
        {bus.btn_mode, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = v;
    endtask

    task automatic press(input bit [4:0] mask);
        drive(mask);
        clk_wait(2);
        drive(5'd0);
        clk_wait(2);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_100hz = 1'b1;
            clk_wait(1);
            bus.tick_100hz = 1'b0;
            clk_wait(3);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({bus.edit_mode, bus.cursor, bus.inc_pulse, bus.dec_pulse, bus.reset_pulse, bus.blink});
    endfunction

    initial begin
        int base_inc;
        int base_dec;
        int base_rst;
        bus.tick_100hz = 1'b0;
        drive(B_MODE);
        reset = 1'b1;
        clk_wait(3);
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
        cmp_en = 1'b1;
        clk_wait(3);
        check("mode_held_through_reset", int'(bus.edit_mode), 0);
        drive(5'd0);
        clk_wait(2);

        press(B_MODE);
        check("enter_edit_mode", int'(bus.edit_mode), 1);
        check("enter_edit_blink", int'(bus.blink), 1);
        press(B_RIGHT);
        press(B_RIGHT);
        check("cursor_after_right_x2", int'(bus.cursor), 2);
        press(B_LEFT);
        press(B_LEFT);
        press(B_LEFT);
        check("cursor_after_left_x3", int'(bus.cursor), 3);

        base_inc = inc_seen; base_dec = dec_seen; base_rst = rst_seen;
        press(B_UP | B_DOWN);
        check("updown_reset_pulses", rst_seen - base_rst, 1);
        check("updown_inc_pulses", inc_seen - base_inc, 0);
        check("updown_dec_pulses", dec_seen - base_dec, 0);

        base_inc = inc_seen;
        drive(B_UP);
        clk_wait(1);
        do_ticks(80);
        drive(5'd0);
        clk_wait(4);
        check("up_held_80_inc_pulses", inc_seen - base_inc, EXP_UP80);
        base_dec = dec_seen;
        drive(B_DOWN);
        clk_wait(1);
        do_ticks(61);
        drive(5'd0);
        clk_wait(4);
        check("down_held_61_dec_pulses", dec_seen - base_dec, EXP_DOWN61);
        check("still_editing_after_holds", int'(bus.edit_mode), 1);

        base_inc = inc_seen;
        press(B_MODE | B_UP);
        check("mode_up_same_clk_edit", int'(bus.edit_mode), 0);
        check("mode_up_same_clk_inc", inc_seen - base_inc, 0);

        press(B_MODE);
        press(B_RIGHT);
        do_ticks(998);
        drive(B_RIGHT);
        bus.tick_100hz = 1'b1;
        clk_wait(1);
        bus.tick_100hz = 1'b0;
        clk_wait(3);
        drive(5'd0);
        clk_wait(1);
        do_ticks(999);
        check("timeout_restarted_edit", int'(bus.edit_mode), 1);
        check("timeout_restarted_cursor", int'(bus.cursor), 2);
        do_ticks(1);
        check("timeout_exit_edit", int'(bus.edit_mode), 0);
        check("timeout_exit_cursor", int'(bus.cursor), 0);

        press(B_MODE);
        press(B_RIGHT);
        drive(B_UP);
        clk_wait(1);
        do_ticks(55);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 0);
        clk_wait(3);
        reset = 1'b0;
        base_inc = inc_seen;
        do_ticks(20);
        check("release_reset_up_held_inc", inc_seen - base_inc, 0);
        check("release_reset_up_held_edit", int'(bus.edit_mode), 0);
        drive(5'd0);
        clk_wait(3);

        cmp_en = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
